addsub_seq: RTL and testbench

Parametrised, multi-cycle adder/subtractor: the sequential successor to the combinational 32-bit `Add32` unit. It accepts one operand pair per transaction over a valid/ready handshake and computes `A±B` in `CHUNK`-bit slices, one slice per clock, with a registered carry between slices. It reports signed or unsigned overflow, and holds the result until the consumer takes it. It sits between the operand-issue logic and result writeback wherever a narrow carry chain is preferred over one full-width adder.

---
 rtl/addsub_seq.sv | 260 ++++++++++++++++++++++++++
 tb/tb_addsub_seq.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_seq.sv
// ---------------------------------------------------------------------------
// addsub_seq
//
// Multi-cycle adder/subtractor. One operand pair is accepted per transaction
// over a valid/ready handshake. A +/- B is then formed CHUNK bits per clock,
// least significant slice first, with the carry between slices held in a
// register. When the last slice is done, the overflow flag is computed. The
// result and flag are held until the consumer takes them.
//
// Handshake rules (both sides):
//   A transfer happens on a rising edge where valid && ready are both high.
//   in_ready is high only in IDLE. out_valid is high only in DONE. While
//   out_valid is high and out_ready is low, result/Overflow do not change.
//   in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
//
// Parameters:
//   WIDTH  operand/result width; must be a multiple of CHUNK
//   CHUNK  bits added per clock; CHUNK == WIDTH gives a one-cycle CALC
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   in_valid     operand pair valid
//   in_ready     block can accept an operand pair (IDLE only)
//   A, B         operands, sampled at acceptance
//   isSub        1: A-B, 0: A+B (sampled at acceptance)
//   isSign       1: two's-complement overflow rule, 0: unsigned rule
//   out_valid    result/Overflow valid (DONE only)
//   out_ready    consumer takes the result
//   result       registered sum/difference
//   Overflow     registered overflow flag
//   dbg_state_o  current FSM state (0 IDLE, 1 CALC, 2 DONE)
//
// Build option:
//   ADDSUB_SAT_EN  When defined, an overflowing result is replaced by the
//                  saturated value as the block enters DONE. Overflow still
//                  reads 1. When not defined, result wraps modulo 2^WIDTH.
// ---------------------------------------------------------------------------
module addsub_seq #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             isSub,
   input  logic             isSign,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             Overflow,
   output logic [1:0]       dbg_state_o
);

   localparam int NSLICE = WIDTH / CHUNK;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICE - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;        // holds B, or ~B for a subtract
   logic             sub_q, sub_d;
   logic             sign_q, sign_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             ovf_q, ovf_d;

   // ------------------------------------------------------------------------
   // Slice datapath
   // ------------------------------------------------------------------------
   logic [CHUNK-1:0] a_slice;
   logic [CHUNK-1:0] b_slice;
   logic [CHUNK:0]   slice_sum;
   logic             last_slice;
   logic             carry_out;
   logic             sum_msb;
   logic             a_msb;
   logic             b_msb;
   logic             ovf_calc;
   logic [WIDTH-1:0] result_slice_wr;

   // Select slice cnt_q of both operands. A loop over constant indices
   // keeps every part-select static.
   always_comb begin
      a_slice = '0;
      b_slice = '0;
      for (int k = 0; k < NSLICE; k++) begin
         if (int'(cnt_q) == k) begin
            a_slice = a_q[k*CHUNK +: CHUNK];
            b_slice = b_q[k*CHUNK +: CHUNK];
         end
      end
   end

   // For a subtract b_q already holds ~B and the carry register started at
   // 1, so this one adder also gives A + ~B + 1 = A - B.
   assign slice_sum = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_q};

   assign last_slice = (cnt_q == LAST_SLICE);
   assign carry_out  = slice_sum[CHUNK];
   assign sum_msb    = slice_sum[CHUNK-1];
   assign a_msb      = a_q[WIDTH-1];
   assign b_msb      = b_q[WIDTH-1];

   // Only meaningful on the last slice, where carry_out and sum_msb belong
   // to the full-width result. For a subtract a missing carry means borrow.
   always_comb begin
      if (sign_q) begin
         ovf_calc = (a_msb == b_msb) && (sum_msb != a_msb);
      end else if (sub_q) begin
         ovf_calc = ~carry_out;
      end else begin
         ovf_calc = carry_out;
      end
   end

   // Current result with the new slice merged into place.
   always_comb begin
      result_slice_wr = result_q;
      for (int k = 0; k < NSLICE; k++) begin
         if (int'(cnt_q) == k) begin
            result_slice_wr[k*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
         end
      end
   end

`ifdef ADDSUB_SAT_EN
   logic [WIDTH-1:0] sat_value;

   // Clamp value for the direction in which the operation overflowed. For
   // signed overflow the sign of A tells which way the true result went.
   always_comb begin
      if (sign_q) begin
         if (a_msb) begin
            sat_value = {1'b1, {(WIDTH-1){1'b0}}};
         end else begin
            sat_value = {1'b0, {(WIDTH-1){1'b1}}};
         end
      end else if (sub_q) begin
         sat_value = '0;
      end else begin
         sat_value = '1;
      end
   end
`endif

   // ------------------------------------------------------------------------
   // FSM: next state and register updates
   // ------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      sub_d    = sub_q;
      sign_d   = sign_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      ovf_d    = ovf_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = A;
               b_d     = isSub ? ~B : B;
               sub_d   = isSub;
               sign_d  = isSign;
               carry_d = isSub;
               cnt_d   = '0;
               state_d = S_CALC;
            end
         end

         S_CALC: begin
            result_d = result_slice_wr;
            carry_d  = carry_out;
            if (last_slice) begin
               ovf_d   = ovf_calc;
               cnt_d   = '0;
               state_d = S_DONE;
`ifdef ADDSUB_SAT_EN
               if (ovf_calc) begin
                  result_d = sat_value;
               end
`endif
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         sub_q    <= 1'b0;
         sign_q   <= 1'b0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sub_q    <= sub_d;
         sign_q   <= sign_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   // Both flags come straight from the state register, so an asynchronous
   // reset drops out_valid and raises in_ready at once.
   assign in_ready    = (state_q == S_IDLE);
   assign out_valid   = (state_q == S_DONE);
   assign result      = result_q;
   assign Overflow    = ovf_q;
   assign dbg_state_o = state_q;

   // ------------------------------------------------------------------------
   // Handshake properties
   // ------------------------------------------------------------------------
   a_no_overlap: assert property (@(posedge clk) disable iff (rst)
      !(in_ready && out_valid));

   a_hold_under_backpressure: assert property (@(posedge clk) disable iff (rst)
      (out_valid && !out_ready) |=> (out_valid && $stable(result) && $stable(Overflow)));

endmodule

// File: tb/tb_addsub_seq.sv
module tb_addsub_seq;

   logic        clk;
   logic        rst;

   // Default-parameter instance (WIDTH=32, CHUNK=8)
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A;
   logic [31:0] B;
   logic        isSub;
   logic        isSign;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        Overflow;
   logic [1:0]  dbg_state;

   // Single-slice instance (WIDTH=32, CHUNK=32)
   logic        in_valid_w;
   logic        in_ready_w;
   logic [31:0] A_w;
   logic [31:0] B_w;
   logic        isSub_w;
   logic        isSign_w;
   logic        out_valid_w;
   logic        out_ready_w;
   logic [31:0] result_w;
   logic        Overflow_w;
   logic [1:0]  dbg_state_w;

   int vec_cnt = 0;
   int err_cnt = 0;

   addsub_seq #(.WIDTH(32), .CHUNK(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .A           (A),
      .B           (B),
      .isSub       (isSub),
      .isSign      (isSign),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .Overflow    (Overflow),
      .dbg_state_o (dbg_state)
   );

   addsub_seq #(.WIDTH(32), .CHUNK(32)) dut_w (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid_w),
      .in_ready    (in_ready_w),
      .A           (A_w),
      .B           (B_w),
      .isSub       (isSub_w),
      .isSign      (isSign_w),
      .out_valid   (out_valid_w),
      .out_ready   (out_ready_w),
      .result      (result_w),
      .Overflow    (Overflow_w),
      .dbg_state_o (dbg_state_w)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   // Called at a sample point (1 time unit after a rising edge). Returns
   // the sampled result when out_valid rises and the number of edges from
   // acceptance to out_valid (-1 on timeout). Leaves out_ready unchanged.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic sign,
                         output logic [31:0] res, output logic ovf,
                         output int lat);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      A = a; B = b; isSub = sub; isSign = sign; in_valid = 1'b1;
      @(posedge clk); #1;
      // Scramble inputs: the operation in flight must not see these.
      in_valid = 1'b0;
      A = $urandom; B = $urandom;
      isSub = 1'($urandom_range(0, 1)); isSign = 1'($urandom_range(0, 1));
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) lat = -1;
      res = result;
      ovf = Overflow;
   endtask

   task automatic run_op_w(input logic [31:0] a, input logic [31:0] b,
                           input logic sub, input logic sign,
                           output logic [31:0] res, output logic ovf,
                           output int lat);
      int n;
      n = 0;
      while (!in_ready_w && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      A_w = a; B_w = b; isSub_w = sub; isSign_w = sign; in_valid_w = 1'b1;
      @(posedge clk); #1;
      in_valid_w = 1'b0;
      A_w = $urandom; B_w = $urandom;
      lat = 0;
      while (!out_valid_w && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid_w) lat = -1;
      res = result_w;
      ovf = Overflow_w;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      vec_cnt++;
      if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      vec_cnt++;
      if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      vec_cnt++;
      if (result !== 32'h0) begin err_cnt++; $display("FAIL reset_result: got %h expected 00000000", result); end
      vec_cnt++;
      if (Overflow !== 1'b0) begin err_cnt++; $display("FAIL reset_overflow: got %b expected 0", Overflow); end
      vec_cnt++;
      if (dbg_state !== 2'd0) begin err_cnt++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
      vec_cnt++;
      if (in_ready_w !== 1'b1 || out_valid_w !== 1'b0) begin
         err_cnt++; $display("FAIL reset_wide: got ready=%b valid=%b expected ready=1 valid=0", in_ready_w, out_valid_w);
      end
   endtask

   task automatic test_unsigned_add();
      logic [31:0] res;
      logic        ovf;
      int          lat;
      logic [31:0] exp;

      run_op(32'd100, 32'd100, 1'b0, 1'b0, res, ovf, lat);
      vec_cnt++;
      if (lat !== 4) begin err_cnt++; $display("FAIL add_latency: got %0d expected 4", lat); end
      vec_cnt++;
      if (res !== 32'd200 || ovf !== 1'b0) begin
         err_cnt++; $display("FAIL add_100_100: got %h/%b expected 000000c8/0", res, ovf);
      end
      consume();
      vec_cnt++;
      if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL add_release: got in_ready=%b expected 1", in_ready); end

      run_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, res, ovf, lat);
`ifdef ADDSUB_SAT_EN
      exp = 32'hFFFF_FFFF;
`else
      exp = 32'h0000_0000;
`endif
      vec_cnt++;
      if (res !== exp || ovf !== 1'b1) begin
         err_cnt++; $display("FAIL add_wrap: got %h/%b expected %h/1", res, ovf, exp);
      end
      consume();

      run_op(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0, res, ovf, lat);
      vec_cnt++;
      if (res !== 32'h2143_6587 || ovf !== 1'b0) begin
         err_cnt++; $display("FAIL add_mixed: got %h/%b expected 21436587/0", res, ovf);
      end
      consume();
   endtask

   task automatic test_sub();
      logic [31:0] res;
      logic        ovf;
      int          lat;
      logic [31:0] exp;

      run_op(32'd5, 32'd7, 1'b1, 1'b0, res, ovf, lat);
`ifdef ADDSUB_SAT_EN
      exp = 32'h0000_0000;
`else
      exp = 32'hFFFF_FFFE;
`endif
      vec_cnt++;
      if (res !== exp || ovf !== 1'b1) begin
         err_cnt++; $display("FAIL usub_5_7: got %h/%b expected %h/1", res, ovf, exp);
      end
      consume();

      run_op(32'd5, 32'd7, 1'b1, 1'b1, res, ovf, lat);
      vec_cnt++;
      if (res !== 32'hFFFF_FFFE || ovf !== 1'b0) begin
         err_cnt++; $display("FAIL ssub_5_7: got %h/%b expected fffffffe/0", res, ovf);
      end
      consume();

      run_op(32'd7, 32'd5, 1'b1, 1'b0, res, ovf, lat);
      vec_cnt++;
      if (res !== 32'd2 || ovf !== 1'b0) begin
         err_cnt++; $display("FAIL usub_7_5: got %h/%b expected 00000002/0", res, ovf);
      end
      consume();
   endtask

   task automatic test_signed_ovf();
      logic [31:0] res;
      logic        ovf;
      int          lat;
      logic [31:0] exp;

      run_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, res, ovf, lat);
`ifdef ADDSUB_SAT_EN
      exp = 32'h7FFF_FFFF;
`else
      exp = 32'h8000_0000;
`endif
      vec_cnt++;
      if (res !== exp || ovf !== 1'b1) begin
         err_cnt++; $display("FAIL sadd_max: got %h/%b expected %h/1", res, ovf, exp);
      end
      consume();

      run_op(32'h8000_0000, 32'd1, 1'b1, 1'b1, res, ovf, lat);
`ifdef ADDSUB_SAT_EN
      exp = 32'h8000_0000;
`else
      exp = 32'h7FFF_FFFF;
`endif
      vec_cnt++;
      if (res !== exp || ovf !== 1'b1) begin
         err_cnt++; $display("FAIL ssub_min: got %h/%b expected %h/1", res, ovf, exp);
      end
      consume();
   endtask

   task automatic test_back_to_back();
      logic [31:0] res;
      logic        ovf;
      int          lat;

      // out_ready held high throughout: ignored in CALC, taken in DONE.
      out_ready = 1'b1;
      run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, res, ovf, lat);
      vec_cnt++;
      if (lat !== 4) begin err_cnt++; $display("FAIL b2b_latency: got %0d expected 4", lat); end
      vec_cnt++;
      if (res !== 32'h0000_0100 || ovf !== 1'b0) begin
         err_cnt++; $display("FAIL b2b_first: got %h/%b expected 00000100/0", res, ovf);
      end
      @(posedge clk); #1;
      vec_cnt++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         err_cnt++; $display("FAIL b2b_idle: got ready=%b valid=%b expected 1/0", in_ready, out_valid);
      end
      out_ready = 1'b0;
      run_op(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b1, res, ovf, lat);
      vec_cnt++;
      if (res !== 32'hFFFF_FFF0 || ovf !== 1'b0) begin
         err_cnt++; $display("FAIL b2b_second: got %h/%b expected fffffff0/0", res, ovf);
      end
      consume();
   endtask

   task automatic test_backpressure();
      logic [31:0] res;
      logic        ovf;
      int          lat;

      run_op(32'd3, 32'd4, 1'b0, 1'b0, res, ovf, lat);
      vec_cnt++;
      if (res !== 32'd7 || ovf !== 1'b0) begin
         err_cnt++; $display("FAIL bp_result: got %h/%b expected 00000007/0", res, ovf);
      end
      for (int i = 0; i < 3; i++) begin
         in_valid = ~in_valid;
         A = $urandom; B = $urandom;
         @(posedge clk); #1;
         vec_cnt++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd7 || Overflow !== 1'b0) begin
            err_cnt++;
            $display("FAIL bp_hold%0d: got valid=%b ready=%b res=%h ovf=%b expected 1/0/00000007/0",
                     i, out_valid, in_ready, result, Overflow);
         end
      end
      in_valid = 1'b0;
      consume();
      vec_cnt++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         err_cnt++; $display("FAIL bp_release: got ready=%b valid=%b expected 1/0", in_ready, out_valid);
      end
      @(posedge clk); #1;
      vec_cnt++;
      if (dbg_state !== 2'd0) begin
         err_cnt++; $display("FAIL bp_no_accept: got state=%0d expected 0", dbg_state);
      end
   endtask

   task automatic test_wide_chunk();
      logic [31:0] res;
      logic        ovf;
      int          lat;

      run_op_w(32'd3, 32'd4, 1'b0, 1'b0, res, ovf, lat);
      vec_cnt++;
      if (lat !== 1) begin err_cnt++; $display("FAIL wide_latency: got %0d expected 1", lat); end
      vec_cnt++;
      if (res !== 32'd7 || ovf !== 1'b0) begin
         err_cnt++; $display("FAIL wide_result: got %h/%b expected 00000007/0", res, ovf);
      end
      out_ready_w = 1'b1;
      @(posedge clk); #1;
      out_ready_w = 1'b0;
      vec_cnt++;
      if (in_ready_w !== 1'b1) begin err_cnt++; $display("FAIL wide_release: got %b expected 1", in_ready_w); end
   endtask

   task automatic test_reset_abort();
      logic [31:0] res;
      logic        ovf;
      int          lat;
      int          seen;

      A = 32'd1; B = 32'd2; isSub = 1'b0; isSign = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;          // accepted on this edge
      in_valid = 1'b0;
      @(posedge clk); #1;          // second CALC cycle
      rst = 1'b1;
      #1;
      vec_cnt++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         err_cnt++; $display("FAIL abort_immediate: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
      end
      vec_cnt++;
      if (result !== 32'h0) begin err_cnt++; $display("FAIL abort_result: got %h expected 00000000", result); end
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      vec_cnt++;
      if (seen !== 0) begin err_cnt++; $display("FAIL abort_no_valid: got %0d valid cycles expected 0", seen); end

      run_op(32'h0000_FFFF, 32'd1, 1'b0, 1'b0, res, ovf, lat);
      vec_cnt++;
      if (res !== 32'h0001_0000 || ovf !== 1'b0) begin
         err_cnt++; $display("FAIL carry_chain: got %h/%b expected 00010000/0", res, ovf);
      end
      vec_cnt++;
      if (lat !== 4) begin err_cnt++; $display("FAIL carry_latency: got %0d expected 4", lat); end
      consume();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst = 1'b1;
      in_valid = 1'b0; A = '0; B = '0; isSub = 1'b0; isSign = 1'b0; out_ready = 1'b0;
      in_valid_w = 1'b0; A_w = '0; B_w = '0; isSub_w = 1'b0; isSign_w = 1'b0; out_ready_w = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst = 1'b0;
      @(posedge clk); #1;
      test_unsigned_add();
      test_sub();
      test_signed_ovf();
      test_back_to_back();
      test_backpressure();
      test_wide_chunk();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
